// File: rtl/bus_pkg.sv
// Shared bus definitions for master2, the memory-backed slaves and their benches.
package bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    ACCESS = 3'd2,
    RESP   = 3'd3
  } slave_state_t;

endpackage

// File: rtl/slave_ram.sv
// Single-port synchronous byte RAM with a registered read port; contents are never reset.
module slave_ram
  import bus_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_slave_mem.sv
// Bus responder owning one address window, backed by a local RAM, with programmable wait states.
// Optional write protection input is enabled by defining SLAVE_WPROT_EN.
module bus_slave_mem
  import bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h1000,
  parameter int                ADDR_BITS   = 8,
  parameter int                WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef SLAVE_WPROT_EN
  input  logic              wprot,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              sel,
  output logic [2:0]        state_show
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  slave_state_t         state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 mode_q, mode_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic                 sel_q, sel_d;
  logic                 ram_we;
  logic                 wr_block;
  logic                 hit;
  logic [DATA_W-1:0]    ram_rdata;

`ifdef SLAVE_WPROT_EN
  assign wr_block = wprot;
`else
  assign wr_block = 1'b0;
`endif

  assign hit = (addr[ADDR_W-1:ADDR_BITS] == BASE_ADDR[ADDR_W-1:ADDR_BITS]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = ready_q;
    sel_d   = sel_q;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid && hit) begin
          addr_d  = addr[ADDR_BITS-1:0];
          mode_d  = mode;
          wdata_d = wdata;
          sel_d   = 1'b1;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_LOAD == 4'd0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (!valid) begin
          state_d = IDLE;
          sel_d   = 1'b0;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // A reset landing on this edge must still cancel the write.
        if (mode_q == MODE_WRITE) begin
          ram_we = !wr_block && rst_n;
        end else begin
          rdata_d = ram_rdata;
        end
        ready_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (!valid) begin
          ready_d = 1'b0;
          sel_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
        sel_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      mode_q  <= MODE_READ;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      sel_q   <= sel_d;
    end
  end

  // Addressing the RAM with the next latched address makes the read data ready by ACCESS.
  slave_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (addr_d),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  assign rdata      = rdata_q;
  assign ready      = ready_q;
  assign sel        = sel_q;
  assign state_show = state_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Bench for bus_slave_mem: a default-latency instance and a zero-wait instance against a memory model.
// Covers the SLAVE_WPROT_EN write-protect path when that macro is defined.
`timescale 1ns/1ps
module tb_bus_slave_mem;
  import bus_pkg::*;

  localparam int WAIT_A = 2;
  localparam int WAIT_B = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_v [2];
  logic        mode_v  [2];
  logic [15:0] addr_v  [2];
  logic [7:0]  wdata_v [2];
  logic [7:0]  rdata_v [2];
  logic        ready_v [2];
  logic        sel_v   [2];
  logic [2:0]  state_v [2];
`ifdef SLAVE_WPROT_EN
  logic        prot_v  [2];
`endif

  logic [7:0]  model_mem [2][256];
  bit          known     [2][256];
  logic [7:0]  model_rd  [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          w;
    bit          m;
    logic [15:0] a;
    logic [7:0]  wd;
    bit          hit;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  bus_slave_mem #(.BASE_ADDR(16'h1000), .ADDR_BITS(8), .WAIT_CYCLES(WAIT_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .valid(valid_v[0]), .mode(mode_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]),
`ifdef SLAVE_WPROT_EN
    .wprot(prot_v[0]),
`endif
    .rdata(rdata_v[0]), .ready(ready_v[0]), .sel(sel_v[0]), .state_show(state_v[0])
  );

  bus_slave_mem #(.BASE_ADDR(16'h1000), .ADDR_BITS(8), .WAIT_CYCLES(WAIT_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .valid(valid_v[1]), .mode(mode_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]),
`ifdef SLAVE_WPROT_EN
    .wprot(prot_v[1]),
`endif
    .rdata(rdata_v[1]), .ready(ready_v[1]), .sel(sel_v[1]), .state_show(state_v[1])
  );

  function automatic int latency(input int w);
    return ((w == 0) ? WAIT_A : WAIT_B) + 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkIdle(input int w, input string tag);
    checkOutput({tag, "_ready"}, 32'(ready_v[w]), 32'd0);
    checkOutput({tag, "_sel"},   32'(sel_v[w]),   32'd0);
    checkOutput({tag, "_state"}, 32'(state_v[w]), 32'd0);
  endtask

  // One full transfer on instance w; latched fields are scrambled after acceptance.
  task automatic applyStimulus(input int w, input bit m, input logic [15:0] a, input logic [7:0] wd,
                               input bit exp_hit, input logic [7:0] exp_rd, input string tag);
    int edges;
    bit commit;
    logic [7:0] held;
    valid_v[w] = 1'b1;
    mode_v[w]  = m;
    addr_v[w]  = a;
    wdata_v[w] = wd;
    if (!exp_hit) begin
      for (int i = 0; i < 10; i++) begin
        tick();
        checkIdle(w, {tag, "_miss"});
      end
      valid_v[w] = 1'b0;
      tick();
      return;
    end
    edges = 0;
    do begin
      tick();
      edges++;
      if (edges == 1) begin
        checkOutput({tag, "_sel_accept"}, 32'(sel_v[w]), 32'd1);
        addr_v[w]  = 16'($urandom);
        wdata_v[w] = 8'($urandom);
        mode_v[w]  = 1'($urandom);
      end
    end while (ready_v[w] !== 1'b1 && edges < 30);
    checkOutput({tag, "_latency"}, 32'(edges), 32'(latency(w)));
    checkOutput({tag, "_rdata"}, 32'(rdata_v[w]), 32'(exp_rd));
    commit = m;
`ifdef SLAVE_WPROT_EN
    commit = m && !prot_v[w];
`endif
    if (commit) begin
      model_mem[w][a[7:0]] = wd;
      known[w][a[7:0]] = 1'b1;
    end else if (!m) begin
      model_rd[w] = model_mem[w][a[7:0]];
    end
    held = rdata_v[w];
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      tick();
      checkOutput({tag, "_ready_hold"}, 32'(ready_v[w]), 32'd1);
      checkOutput({tag, "_rdata_hold"}, 32'(rdata_v[w]), 32'(held));
    end
    valid_v[w] = 1'b0;
    tick();
    checkIdle(w, {tag, "_release"});
  endtask

  initial begin
    #500us;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  seq [4];
    logic [15:0] a;
    bit          m;
    int          w;
    seq = '{3'd1, 3'd1, 3'd2, 3'd3};

    for (int i = 0; i < 2; i++) begin
      valid_v[i] = 1'b0; mode_v[i] = 1'b0; addr_v[i] = 16'h0; wdata_v[i] = 8'h0;
      model_rd[i] = 8'h00;
`ifdef SLAVE_WPROT_EN
      prot_v[i] = 1'b0;
`endif
      for (int j = 0; j < 256; j++) known[i][j] = 1'b0;
    end

    tbl[0] = '{w: 0, m: 1'b1, a: 16'h1034, wd: 8'hAB, hit: 1'b1, rd: 8'h00};
    tbl[1] = '{w: 0, m: 1'b0, a: 16'h1034, wd: 8'h00, hit: 1'b1, rd: 8'hAB};
    tbl[2] = '{w: 0, m: 1'b0, a: 16'h2034, wd: 8'h00, hit: 1'b0, rd: 8'h00};
    tbl[3] = '{w: 0, m: 1'b1, a: 16'h1010, wd: 8'h00, hit: 1'b1, rd: 8'hAB};
    tbl[4] = '{w: 0, m: 1'b1, a: 16'h1020, wd: 8'h3C, hit: 1'b1, rd: 8'hAB};
    tbl[5] = '{w: 1, m: 1'b1, a: 16'h10FF, wd: 8'hCD, hit: 1'b1, rd: 8'h00};
    tbl[6] = '{w: 1, m: 1'b0, a: 16'h10FF, wd: 8'h00, hit: 1'b1, rd: 8'hCD};

    rst_n = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      checkIdle(i, "reset");
      checkOutput("reset_rdata", 32'(rdata_v[i]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i].w, tbl[i].m, tbl[i].a, tbl[i].wd, tbl[i].hit, tbl[i].rd, $sformatf("tbl%0d", i));
    end

    // State walk of a default-latency read.
    valid_v[0] = 1'b1; mode_v[0] = MODE_READ; addr_v[0] = 16'h1034;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("seq_state%0d", i), 32'(state_v[0]), 32'(seq[i]));
    end
    checkOutput("seq_ready", 32'(ready_v[0]), 32'd1);
    checkOutput("seq_rdata", 32'(rdata_v[0]), 32'hAB);
    valid_v[0] = 1'b0;
    tick();
    checkIdle(0, "seq_end");
    model_rd[0] = 8'hAB;

    // Abort during WAIT must not touch the RAM.
    valid_v[0] = 1'b1; mode_v[0] = MODE_WRITE; addr_v[0] = 16'h1010; wdata_v[0] = 8'h55;
    tick();
    checkOutput("abort_state_wait", 32'(state_v[0]), 32'd1);
    valid_v[0] = 1'b0;
    tick();
    checkIdle(0, "abort");
    tick();
    checkOutput("abort_no_ready", 32'(ready_v[0]), 32'd0);
    applyStimulus(0, MODE_READ, 16'h1010, 8'h00, 1'b1, 8'h00, "abort_readback");

    // Reset while a write sits in WAIT.
    valid_v[0] = 1'b1; mode_v[0] = MODE_WRITE; addr_v[0] = 16'h1020; wdata_v[0] = 8'h99;
    tick();
    tick();
    checkOutput("rstmid_in_wait", 32'(state_v[0]), 32'd1);
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      checkIdle(i, "rstmid");
      checkOutput("rstmid_rdata", 32'(rdata_v[i]), 32'd0);
      model_rd[i] = 8'h00;
    end
    valid_v[0] = 1'b0;
    rst_n = 1'b1;
    tick();
    applyStimulus(0, MODE_READ, 16'h1020, 8'h00, 1'b1, 8'h3C, "rstmid_readback");

`ifdef SLAVE_WPROT_EN
    applyStimulus(0, MODE_WRITE, 16'h1001, 8'h11, 1'b1, model_rd[0], "wprot_preset");
    prot_v[0] = 1'b1;
    applyStimulus(0, MODE_WRITE, 16'h1001, 8'h77, 1'b1, model_rd[0], "wprot_blocked");
    prot_v[0] = 1'b0;
    applyStimulus(0, MODE_READ, 16'h1001, 8'h00, 1'b1, 8'h11, "wprot_readback");
`endif

    // Random traffic on both instances against the model.
    for (int n = 0; n < 40; n++) begin
      w = int'($urandom_range(0, 1));
      m = 1'($urandom);
      a = {8'h10, 8'($urandom_range(0, 15))};
      if ($urandom_range(0, 7) == 0) begin
        a[15:8] = 8'($urandom_range(8'h11, 8'hFF));
        applyStimulus(w, m, a, 8'h00, 1'b0, 8'h00, "rnd_miss");
      end else begin
        if (!m && !known[w][a[7:0]]) m = 1'b1;
        applyStimulus(w, m, a, 8'($urandom), 1'b1,
                      m ? model_rd[w] : model_mem[w][a[7:0]], $sformatf("rnd%0d", n));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_slave_mem.md
Name: bus_slave_mem

Overview:
Responder end of the system bus driven by master2. It decodes the master's addr/mode/wdata/valid request against its own address window. On a hit it waits a programmable number of cycles, then performs a read or write on a local synchronous RAM. It completes the transfer with a four-phase ready handshake. Several instances share the bus, each owning one address window.

Parameters:
BASE_ADDR, 16'h1000, base of the owned window; the low ADDR_BITS bits are ignored for decode
ADDR_BITS, 8, local RAM address width; depth = 2**ADDR_BITS bytes
WAIT_CYCLES, 2, wait states inserted before the access (0..15)

Ports:
clk  in  1  system clock; all logic on the rising edge
rst_n  in  1  reset, synchronous, active-low
valid  in  1  master request strobe, held high until ready is seen
mode  in  1  0 = read, 1 = write
addr  in  16  byte address
wdata  in  8  write data
rdata  out  8  read data; valid while ready=1 on a read
ready  out  1  transfer complete; held until valid falls
sel  out  1  high from request acceptance until return to IDLE (window hit, busy)
state_show  out  3  current FSM state code, for debug/LEDs

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, ready=0, sel=0, rdata=8'h00, state_show=0, wait counter=0. RAM contents are not reset. Reset overrides any in-flight transfer; a write not yet in ACCESS is never committed.
- Hit: addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]. Miss: remain in IDLE with all outputs unchanged; the request is never acknowledged.
- State codes: IDLE=0, WAIT=1, ACCESS=2, RESP=3.
- IDLE: valid=1 and hit -> latch addr[ADDR_BITS-1:0], mode and wdata; set sel=1; load counter=WAIT_CYCLES; go to WAIT, or directly to ACCESS if WAIT_CYCLES==0.
- WAIT: decrement the counter each cycle; when counter==1 go to ACCESS. If valid=0 is sampled, abort: go to IDLE with sel=0 and no RAM access.
- ACCESS: always a single cycle, committed regardless of valid. On a write, RAM[latched addr] <= latched wdata. On a read, rdata <= RAM[latched addr]. Go to RESP with ready registered high.
- RESP: hold ready=1 and rdata stable while valid=1. When valid=0 is sampled: ready=0, sel=0, go to IDLE. On a write transfer, rdata holds its previous value.
- Latency: ready rises WAIT_CYCLES+2 edges after the edge that samples valid=1 in IDLE (4 at the default).
- A new request is accepted only in IDLE, so back-to-back transfers require valid to fall for at least one cycle.
- Latched request fields are used for the whole transfer; changes on addr, mode or wdata after acceptance are ignored.
- mode and wdata are don't-care while valid=0.

Optional Feature:
Macro SLAVE_WPROT_EN.
- Defined: adds input port wprot (1 bit). If wprot=1 during ACCESS, the write is suppressed. The handshake still completes normally (ready asserted) and rdata is unchanged. Reads are unaffected.
- Undefined: no wprot port; every write is committed.

Decomposition:
- Package bus_pkg: ADDR_W=16, DATA_W=8, MODE_READ=1'b0, MODE_WRITE=1'b1, and the enum slave_state_t {IDLE, WAIT, ACCESS, RESP} with 3-bit encoding 0..3. master2 and the testbenches share this package.
- Sub-module slave_ram: single-port synchronous RAM with inputs we, addr[ADDR_BITS-1:0], wdata[7:0] and registered output rdata[7:0], instantiated once.
- The FSM, address decode and counter stay in bus_slave_mem.

Test Plan:
- Write then read, defaults: write 0x1034=8'hAB; ready rises 4 edges after valid; drop valid; read 0x1034 -> rdata=8'hAB with ready=1, state_show sequence 0,1,1,2,3,0.
- Miss: valid=1, addr=16'h2034 held 10 cycles -> ready=0, sel=0, state_show=0 throughout.
- Abort in WAIT: write 0x1010=8'h55, drop valid 1 cycle after acceptance -> IDLE, no ready; a later read of 0x1010 returns the prior value (8'h00 after a preset write of 8'h00).
- Reset mid-transfer: assert rst_n=0 in WAIT during a write to 0x1020 -> next edge ready=0, sel=0, rdata=8'h00, state_show=0; location unchanged.
- WAIT_CYCLES=0: read 0x10FF preloaded with 8'hCD -> ready after 2 edges, rdata=8'hCD; ready held until valid falls, then deasserts next edge.
- SLAVE_WPROT_EN with wprot=1: write 0x1001=8'h77 completes with ready; a read returns the old value 8'h11.
